// File: rtl/endereco_absoluto_pkg.sv
// Shared constants and state encoding for the process address translator
// and its context-switch sequencer.
package endereco_absoluto_pkg;

   localparam int unsigned          ID_W         = 4;
   localparam int unsigned          N_CTX        = 11;
   localparam logic [ID_W-1:0]      MAX_PROC     = 4'd10;
   localparam logic [31:0]          TAM_PROCESSO = 32'd300;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SALVA   = 2'd1,
      CALCULA = 2'd2,
      FIM     = 2'd3
   } estado_t;

endpackage

// File: rtl/endereco_absoluto_tabela.sv
// Context table: one saved PC per process, with a valid bit per entry.
// Data words carry no reset; only the valid bits are cleared.
module tabela_contexto
   import endereco_absoluto_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            we_i,
   input  logic [ID_W-1:0] waddr_i,
   input  logic [31:0]     wdata_i,
   input  logic [ID_W-1:0] raddr_i,
   output logic [31:0]     rdata_o,
   output logic            rvalid_o
);

   logic [31:0]      dado_q [N_CTX];
   logic [N_CTX-1:0] valido_q;

   always_ff @(posedge clk_i) begin
      if (we_i && (waddr_i <= MAX_PROC)) begin
         dado_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valido_q <= '0;
      end else if (we_i && (waddr_i <= MAX_PROC)) begin
         valido_q[waddr_i] <= 1'b1;
      end
   end

   always_comb begin
      rdata_o  = '0;
      rvalid_o = 1'b0;
      if (raddr_i <= MAX_PROC) begin
         rdata_o  = dado_q[raddr_i];
         rvalid_o = valido_q[raddr_i];
      end
   end

endmodule

// File: rtl/endereco_absoluto.sv
// Relative-to-absolute address translator with a multi-cycle context switch:
// saves the running PC, computes the new base by repeated addition, restores.
module endereco_absoluto
   import endereco_absoluto_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        troca_req,
   input  logic [3:0]  proc_id,
   input  logic [31:0] pc_atual,
   input  logic [31:0] end_relativo,
   output logic        busy,
   output logic        done,
   output logic        erro,
   output logic [3:0]  processo_atual,
   output logic [31:0] base_atual,
   output logic [31:0] pc_inicio,
   output logic [31:0] end_absoluto,
   output logic        fora_limite
);

   estado_t         estado_q, estado_d;
   logic [ID_W-1:0] alvo_q, alvo_d;
   logic [ID_W-1:0] cont_q, cont_d;
   logic [31:0]     acc_q, acc_d;
   logic [ID_W-1:0] proc_q, proc_d;
   logic [31:0]     base_q, base_d;
   logic [31:0]     pc_q, pc_d;
   logic            done_q, done_d;
   logic            erro_q, erro_d;

   logic            tab_we;
   logic [31:0]     tab_dado;
   logic            tab_valido;

   tabela_contexto u_tabela (
      .clk_i    (clock),
      .rst_ni   (reset),
      .we_i     (tab_we),
      .waddr_i  (proc_q),
      .wdata_i  (pc_atual),
      .raddr_i  (alvo_q),
      .rdata_o  (tab_dado),
      .rvalid_o (tab_valido)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= IDLE;
         alvo_q   <= '0;
         cont_q   <= '0;
         acc_q    <= '0;
         proc_q   <= '0;
         base_q   <= '0;
         pc_q     <= '0;
         done_q   <= 1'b0;
         erro_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         alvo_q   <= alvo_d;
         cont_q   <= cont_d;
         acc_q    <= acc_d;
         proc_q   <= proc_d;
         base_q   <= base_d;
         pc_q     <= pc_d;
         done_q   <= done_d;
         erro_q   <= erro_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      alvo_d   = alvo_q;
      cont_d   = cont_q;
      acc_d    = acc_q;
      proc_d   = proc_q;
      base_d   = base_q;
      pc_d     = pc_q;
      done_d   = 1'b0;
      erro_d   = 1'b0;
      tab_we   = 1'b0;

      unique case (estado_q)
         IDLE: begin
            if (troca_req) begin
               if (proc_id <= MAX_PROC) begin
                  alvo_d   = proc_id;
                  estado_d = SALVA;
               end else begin
                  erro_d = 1'b1;
               end
            end
         end
         SALVA: begin
            tab_we   = 1'b1;
            acc_d    = '0;
            cont_d   = alvo_q;
            estado_d = CALCULA;
         end
         CALCULA: begin
            // base = 300 * alvo built by alvo additions, plus one cycle to see zero
            if (cont_q == '0) begin
               estado_d = FIM;
            end else begin
               acc_d  = acc_q + TAM_PROCESSO;
               cont_d = cont_q - 1'b1;
            end
         end
         FIM: begin
            done_d   = 1'b1;
            proc_d   = alvo_q;
            base_d   = acc_q;
            pc_d     = tab_valido ? tab_dado : acc_q;
            estado_d = IDLE;
         end
         default: begin
            estado_d = IDLE;
         end
      endcase
   end

   assign busy           = (estado_q != IDLE);
   assign done           = done_q;
   assign erro           = erro_q;
   assign processo_atual = proc_q;
   assign base_atual     = base_q;
   assign pc_inicio      = pc_q;
   assign end_absoluto   = base_q + end_relativo;
   assign fora_limite    = (end_relativo >= TAM_PROCESSO);

endmodule

// File: tb/tb_endereco_absoluto.sv
// Randomized self-checking bench for endereco_absoluto against a
// process-level reference model (saved-PC array, base = 300 * id).
module tb_endereco_absoluto;

   logic        clock;
   logic        reset;
   logic        troca_req;
   logic [3:0]  proc_id;
   logic [31:0] pc_atual;
   logic [31:0] end_relativo;
   logic        busy;
   logic        done;
   logic        erro;
   logic [3:0]  processo_atual;
   logic [31:0] base_atual;
   logic [31:0] pc_inicio;
   logic [31:0] end_absoluto;
   logic        fora_limite;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [31:0] m_ctx [11];
   bit          m_val [11];
   int unsigned m_cur;
   logic [31:0] m_base;
   logic [31:0] m_pc;

   endereco_absoluto dut (
      .clock          (clock),
      .reset          (reset),
      .troca_req      (troca_req),
      .proc_id        (proc_id),
      .pc_atual       (pc_atual),
      .end_relativo   (end_relativo),
      .busy           (busy),
      .done           (done),
      .erro           (erro),
      .processo_atual (processo_atual),
      .base_atual     (base_atual),
      .pc_inicio      (pc_inicio),
      .end_absoluto   (end_absoluto),
      .fora_limite    (fora_limite)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 11; i++) m_val[i] = 1'b0;
      m_cur  = 0;
      m_base = 0;
      m_pc   = 0;
   endtask

   task automatic model_switch(input int unsigned id, input logic [31:0] pc);
      m_ctx[m_cur] = pc;
      m_val[m_cur] = 1'b1;
      m_pc   = m_val[id] ? m_ctx[id] : 300 * id;
      m_cur  = id;
      m_base = 300 * id;
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, "_proc"}, {28'd0, processo_atual}, m_cur);
      check_eq({tag, "_base"}, base_atual, m_base);
      check_eq({tag, "_pc"},   pc_inicio, m_pc);
   endtask

   task automatic check_addr(input logic [31:0] rel);
      end_relativo = rel;
      #1;
      check_eq("end_absoluto", end_absoluto, m_base + rel);
      check_eq("fora_limite", {31'd0, fora_limite}, {31'd0, (rel >= 32'd300)});
   endtask

   // Waits for done after an accept; returns the edge count (41 on timeout).
   task automatic wait_done(output int n);
      n = 0;
      while (n <= 40) begin
         @(posedge clock); #1;
         n++;
         if (done) break;
         check_eq("busy_during", {31'd0, busy}, 32'd1);
      end
   endtask

   task automatic do_switch(input int unsigned id, input logic [31:0] pc, input bit hold);
      int n;
      @(negedge clock);
      troca_req = 1'b1;
      proc_id   = id[3:0];
      pc_atual  = pc;
      @(posedge clock); #1;
      check_eq("busy_accept", {31'd0, busy}, 32'd1);
      if (!hold) troca_req = 1'b0;
      wait_done(n);
      check_eq("done_latency", n, id + 3);
      model_switch(id, pc);
      check_eq("busy_at_done", {31'd0, busy}, 32'd0);
      check_state("switch");
      check_addr($urandom);
      if (hold) begin
         @(posedge clock); #1;
         check_eq("reaccept", {31'd0, busy}, 32'd1);
         check_eq("single_done", {31'd0, done}, 32'd0);
         troca_req = 1'b0;
         wait_done(n);
         check_eq("done_latency2", n, id + 3);
         model_switch(id, pc);
         check_state("switch2");
      end
      @(posedge clock); #1;
      check_eq("done_pulse", {31'd0, done}, 32'd0);
   endtask

   task automatic do_erro(input int unsigned id);
      @(negedge clock);
      troca_req = 1'b1;
      proc_id   = id[3:0];
      pc_atual  = $urandom;
      @(posedge clock); #1;
      troca_req = 1'b0;
      check_eq("erro_pulse", {31'd0, erro}, 32'd1);
      check_eq("erro_busy", {31'd0, busy}, 32'd0);
      @(posedge clock); #1;
      check_eq("erro_clear", {31'd0, erro}, 32'd0);
      check_eq("erro_busy2", {31'd0, busy}, 32'd0);
      check_state("erro");
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
      check_eq({tag, "_erro"}, {31'd0, erro}, 32'd0);
      check_state(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      troca_req    = 1'b0;
      proc_id      = '0;
      pc_atual     = '0;
      end_relativo = '0;
      reset        = 1'b0;
      model_reset();
      #2;
      check_reset_outputs("reset");
      @(negedge clock);
      reset = 1'b1;

      // Basic switch, then round trip restoring saved PCs
      do_switch(3, 32'd17, 1'b0);
      check_eq("pc_first", pc_inicio, 32'd900);
      do_switch(0, 32'd950, 1'b0);
      check_eq("pc_restore0", pc_inicio, 32'd17);
      do_switch(3, 32'd40, 1'b0);
      check_eq("pc_restore3", pc_inicio, 32'd950);

      do_erro(11);
      do_switch(10, 32'd5, 1'b0);
      check_eq("base_max", base_atual, 32'd3000);

      // Request held high across a whole switch
      do_switch(5, 32'd77, 1'b1);

      // Reset during CALCULA of a switch to 7
      @(negedge clock);
      troca_req = 1'b1;
      proc_id   = 4'd7;
      pc_atual  = 32'd123;
      @(posedge clock); #1;
      troca_req = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("abort");
      @(negedge clock);
      reset = 1'b1;
      do_switch(7, 32'd321, 1'b0);
      check_eq("pc_no_stale", pc_inicio, 32'd2100);

      do_switch(2, 32'd9, 1'b0);
      check_addr(32'd299);
      check_eq("addr299", end_absoluto, 32'd899);
      check_addr(32'd300);
      check_eq("addr300", end_absoluto, 32'd900);
      check_addr(32'hFFFF_FFFF);

      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 4) == 0) do_erro($urandom_range(11, 15));
         else do_switch($urandom_range(0, 10), $urandom, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/endereco_absoluto.md
ENDERECO_ABSOLUTO -- requirements
Module: endereco_absoluto

Interface
REQ-001: clock  input  1  system clock; all state updates on rising edge.
REQ-002: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-003: troca_req  input  1  context-switch request; sampled only in IDLE.
REQ-004: proc_id  input  4  target process number for troca_req (valid 0..10).
REQ-005: pc_atual  input  32  absolute PC of the running process, saved on switch.
REQ-006: end_relativo  input  32  process-relative address to translate.
REQ-007: busy  output  1  switch in progress.
REQ-008: done  output  1  one-cycle pulse: switch complete, pc_inicio valid.
REQ-009: erro  output  1  one-cycle pulse: request rejected (proc_id > 10).
REQ-010: processo_atual  output  4  process currently owning the CPU.
REQ-011: base_atual  output  32  absolute base of processo_atual (= 300 * processo_atual).
REQ-012: pc_inicio  output  32  absolute PC at which the new process resumes.
REQ-013: end_absoluto  output  32  base_atual + end_relativo, combinational, modulo 2^32.
REQ-014: fora_limite  output  1  combinational: end_relativo >= 300.

Function
REQ-015: FSM states IDLE, SALVA, CALCULA, FIM; unreachable encodings SHALL return to IDLE.
REQ-016: IDLE, troca_req=1, proc_id<=10: accept; latch proc_id into alvo; next SALVA.
REQ-017: IDLE, troca_req=1, proc_id>10: erro=1 next cycle only; stay IDLE; no other state change.
REQ-018: SALVA (1 cycle): write pc_atual into context table entry processo_atual, set its valid bit; clear accumulator and load counter with alvo; next CALCULA.
REQ-019: CALCULA: counter=0 -> FIM; else accumulator += 300, counter -= 1; lasts alvo+1 cycles.
REQ-020: FIM (1 cycle): done=1; processo_atual<=alvo; base_atual<=accumulator; pc_inicio<=table[alvo] if its valid bit set, else accumulator; next IDLE.
REQ-021: done SHALL rise exactly alvo+3 rising edges after the accepting edge and hold 1 cycle; outputs of REQ-020 update on that same edge.
REQ-022: busy=1 in SALVA, CALCULA, FIM; 0 in IDLE.
REQ-023: troca_req while busy SHALL be ignored (not queued).
REQ-024: Switch to the same process is legal: save then restore, pc_inicio equals pc_atual sampled in SALVA.
REQ-025: Accumulator arithmetic 32-bit unsigned; maximum 3000, no overflow.
REQ-026: end_absoluto and fora_limite SHALL track inputs in every state; base_atual changes only in FIM.

Reset
REQ-027: reset=0 asynchronously forces IDLE, busy=0, done=0, erro=0, processo_atual=0, base_atual=0, pc_inicio=0, accumulator/counter/alvo=0, all valid bits cleared.
REQ-028: Reset mid-switch aborts it; no table entry or output from the aborted switch survives.
REQ-029: Table data words need not be reset; valid bits gate their use.

Structure
REQ-030: Shared package holds TAM_PROCESSO=300, MAX_PROC=10, ID width 4, state encoding.
REQ-031: Context table SHALL be sub-module tabela_contexto: 11 x 32-bit words plus 11 valid bits, one write port, one asynchronous read port, valid clear on reset.
REQ-032: Expected size 120-400 RTL lines total.

Verification
REQ-033: Reset, then troca_req with proc_id=3, pc_atual=17 -> done 6 edges after accept, processo_atual=3, base_atual=900, pc_inicio=900, table[0]=17 valid.
REQ-034: From process 3, switch to 0 with pc_atual=950, then back to 3 with pc_atual=40 -> second done gives pc_inicio=950, base_atual=900; first gives pc_inicio=17.
REQ-035: proc_id=11 in IDLE -> erro pulse 1 cycle, busy stays 0, processo_atual unchanged; proc_id=10 -> base_atual=3000 after 13 edges.
REQ-036: troca_req held high during a switch to 5 -> exactly one done; second request accepted only after return to IDLE.
REQ-037: Reset asserted in CALCULA of switch to 7 -> immediate IDLE, all outputs 0, next switch to 7 returns pc_inicio=2100 (no stale valid).
REQ-038: processo_atual=2, end_relativo=299 -> end_absoluto=899, fora_limite=0; end_relativo=300 -> 900, fora_limite=1.
